sudoku_input_fsm: RTL and testbench

- Control stage directly upstream of the sudoku datapath.
- Converts raw player button levels into the datapath control strobes: set_board, register_inp_flag, dp_check, reg_choose, value_inp, won and try_again_flag.
- Tracks a cursor over the 4x4 board and rejects writes to locked (given) cells using the datapath's fill_flag.
- Sequences each write into a check cycle, samples solved, and enforces a move budget.

---
 rtl/sudoku_input_fsm.sv | 143 ++++++++++++++
 tb/tb_sudoku_input_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_input_fsm.sv
// Input controller for the sudoku datapath: turns button levels into control strobes,
// tracks the cursor, refuses writes to locked cells and enforces a move budget.
module sudoku_input_fsm #(
  parameter int MAX_MOVES = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             btn_start,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_enter,
  input  logic [1:0]       key_value,
  input  logic [1:0]       difficulty_sel,
  input  logic [15:0]      fill_flag,
  input  logic             solved,
  output logic             set_board,
  output logic [1:0]       difficulty,
  output logic             register_inp_flag,
  output logic             dp_check,
  output logic [3:0]       reg_choose,
  output logic [1:0]       value_inp,
  output logic             won,
  output logic             try_again_flag,
  output logic             reject,
  output logic [CNT_W-1:0] move_count
);

  // state | meaning
  // IDLE  | waiting for start; difficulty captured on the start press
  // LOAD  | one-cycle board load; cursor and move count already cleared
  // PLAY  | cursor moves, enter on the selected cell
  // WRITE | one-cycle write strobe; move counted
  // CHECK | one-cycle check strobe
  // EVAL  | solved sampled; decides win, retry or keep playing
  // WON   | won held until start returns to IDLE
  // RETRY | try_again_flag held until start reloads the board

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_WRITE, S_CHECK, S_EVAL, S_WON, S_RETRY
  } state_t;

  localparam logic [CNT_W-1:0] MOVES_MAX = CNT_W'(MAX_MOVES);

  state_t state, state_nxt;

  // bit order: start, up, down, left, right, enter
  logic [5:0] btn_cur, btn_prev, btn_ev;
  logic       start_ev, up_ev, down_ev, left_ev, right_ev, enter_ev;
  logic [1:0] row, col;
  logic       cell_locked, enter_ok, enter_locked;

  assign btn_cur  = {btn_start, btn_up, btn_down, btn_left, btn_right, btn_enter};
  assign btn_ev   = btn_cur & ~btn_prev;
  assign start_ev = btn_ev[5];
  assign up_ev    = btn_ev[4];
  assign down_ev  = btn_ev[3];
  assign left_ev  = btn_ev[2];
  assign right_ev = btn_ev[1];
  assign enter_ev = btn_ev[0];

  assign cell_locked  = fill_flag[{row, col}];
  assign enter_ok     = (state == S_PLAY) && enter_ev && !cell_locked;
  assign enter_locked = (state == S_PLAY) && enter_ev && cell_locked;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ev) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_PLAY;
      S_PLAY:  if (enter_ok) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_EVAL;
      S_EVAL: begin
        if (solved)                       state_nxt = S_WON;
        else if (move_count == MOVES_MAX) state_nxt = S_RETRY;
        else                              state_nxt = S_PLAY;
      end
      S_WON:   if (start_ev) state_nxt = S_IDLE;
      S_RETRY: if (start_ev) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state      <= S_IDLE;
      btn_prev   <= '1;
      row        <= '0;
      col        <= '0;
      difficulty <= '0;
      value_inp  <= '0;
      move_count <= '0;
      reject     <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn_prev <= btn_cur;
      reject   <= enter_locked;

      if (state == S_IDLE && start_ev)
        difficulty <= difficulty_sel;

      // cleared on the way into LOAD so the load cycle already shows a fresh board
      if (start_ev && (state == S_IDLE || state == S_RETRY)) begin
        row        <= '0;
        col        <= '0;
        move_count <= '0;
      end

      // leaving WON is a soft return to the power-up picture
      if (state == S_WON && start_ev) begin
        row        <= '0;
        col        <= '0;
        move_count <= '0;
        difficulty <= '0;
        value_inp  <= '0;
      end

      if (state == S_PLAY && !enter_ev) begin
        if (up_ev)         row <= row - 2'd1;
        else if (down_ev)  row <= row + 2'd1;
        else if (left_ev)  col <= col - 2'd1;
        else if (right_ev) col <= col + 2'd1;
      end

      if (enter_ok)
        value_inp <= key_value;

      if (state == S_WRITE && move_count != MOVES_MAX)
        move_count <= move_count + CNT_W'(1);
    end
  end

  assign set_board         = (state == S_LOAD);
  assign register_inp_flag = (state == S_WRITE);
  assign dp_check          = (state == S_CHECK);
  assign won               = (state == S_WON);
  assign try_again_flag    = (state == S_RETRY);
  assign reg_choose        = {row, col};

endmodule

// File: tb/tb_sudoku_input_fsm.sv
// Bench for sudoku_input_fsm: directed game scenarios followed by random play,
// checked each cycle against a transaction-level model of the game.
module tb_sudoku_input_fsm;

  localparam int MAX_MOVES = 2;
  localparam int CNT_W     = 6;

  logic             clka = 1'b0;
  logic             restart = 1'b1;
  logic             btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic             btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;
  logic [1:0]       key_value = 2'd0;
  logic [1:0]       difficulty_sel = 2'd0;
  logic [15:0]      fill_flag = 16'h0000;
  logic             solved = 1'b0;
  logic             set_board, register_inp_flag, dp_check, won, try_again_flag, reject;
  logic [1:0]       difficulty, value_inp;
  logic [3:0]       reg_choose;
  logic [CNT_W-1:0] move_count;

  always #5 clka = ~clka;

  sudoku_input_fsm #(.MAX_MOVES(MAX_MOVES), .CNT_W(CNT_W)) dut (
    .clka(clka), .restart(restart),
    .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_enter(btn_enter),
    .key_value(key_value), .difficulty_sel(difficulty_sel),
    .fill_flag(fill_flag), .solved(solved),
    .set_board(set_board), .difficulty(difficulty),
    .register_inp_flag(register_inp_flag), .dp_check(dp_check),
    .reg_choose(reg_choose), .value_inp(value_inp), .won(won),
    .try_again_flag(try_again_flag), .reject(reject), .move_count(move_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // game model: cursor, moves, latched values and the strobes expected this cycle
  int         m_row, m_col, m_moves;
  logic [1:0] m_diff, m_val;
  bit         m_set, m_wr, m_chk, m_rej, m_won, m_retry;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/set_board"},   32'(set_board),         32'(m_set));
    chk({tag, "/difficulty"},  32'(difficulty),        32'(m_diff));
    chk({tag, "/write"},       32'(register_inp_flag), 32'(m_wr));
    chk({tag, "/dp_check"},    32'(dp_check),          32'(m_chk));
    chk({tag, "/reg_choose"},  32'(reg_choose),        32'(m_row * 4 + m_col));
    chk({tag, "/value_inp"},   32'(value_inp),         32'(m_val));
    chk({tag, "/won"},         32'(won),               32'(m_won));
    chk({tag, "/try_again"},   32'(try_again_flag),    32'(m_retry));
    chk({tag, "/reject"},      32'(reject),            32'(m_rej));
    chk({tag, "/move_count"},  32'(move_count),        32'(m_moves));
  endtask

  task automatic model_clear();
    m_row = 0; m_col = 0; m_moves = 0;
    m_diff = 2'd0; m_val = 2'd0;
    m_set = 0; m_wr = 0; m_chk = 0; m_rej = 0; m_won = 0; m_retry = 0;
  endtask

  task automatic drive_dir(input int d, input logic v);
    case (d)
      0: btn_up    = v;
      1: btn_down  = v;
      2: btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press_start_idle(input logic [1:0] diff);
    difficulty_sel = diff;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    difficulty_sel = ~diff;
    m_diff = diff; m_set = 1; m_row = 0; m_col = 0; m_moves = 0;
    check_all("load");
    tick();
    m_set = 0;
    check_all("play_entry");
  endtask

  task automatic start_in_retry();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    m_retry = 0; m_set = 1; m_row = 0; m_col = 0; m_moves = 0;
    check_all("retry_load");
    tick();
    m_set = 0;
    check_all("retry_play");
  endtask

  task automatic start_in_won();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    model_clear();
    check_all("won_to_idle");
    tick();
    check_all("idle_hold");
  endtask

  task automatic move(input int d);
    drive_dir(d, 1'b1);
    tick();
    drive_dir(d, 1'b0);
    case (d)
      0: m_row = (m_row + 3) % 4;
      1: m_row = (m_row + 1) % 4;
      2: m_col = (m_col + 3) % 4;
      default: m_col = (m_col + 1) % 4;
    endcase
    check_all("move");
    tick();
    check_all("move_hold");
  endtask

  task automatic enter(input logic [1:0] key, input bit solv, input bit noise, input bit with_up);
    bit locked;
    int nb;
    nb = $urandom_range(0, 3);
    locked = fill_flag[m_row * 4 + m_col];
    key_value = key;
    btn_enter = 1'b1;
    if (with_up) btn_up = 1'b1;
    tick();
    btn_enter = 1'b0;
    btn_up = 1'b0;
    key_value = ~key;
    if (locked) begin
      m_rej = 1;
      check_all("reject");
      m_rej = 0;
      tick();
      check_all("after_reject");
    end else begin
      m_val = key; m_wr = 1;
      check_all("write");
      if (noise) drive_dir(nb, 1'b1);
      solved = solv;
      tick();
      if (noise) drive_dir(nb, 1'b0);
      m_wr = 0; m_chk = 1;
      if (m_moves < MAX_MOVES) m_moves++;
      check_all("check");
      tick();
      m_chk = 0;
      check_all("eval");
      tick();
      solved = 1'b0;
      if (solv) m_won = 1;
      else if (m_moves == MAX_MOVES) m_retry = 1;
      check_all("outcome");
    end
  endtask

  int act;

  initial begin
    model_clear();
    tick();
    restart = 1'b0;
    check_all("reset");
    tick();
    check_all("idle");

    press_start_idle(2'b10);
    chk("difficulty_latched", 32'(difficulty), 32'd2);

    move(3); move(3); move(3);
    chk("cursor_c3", 32'(reg_choose), 32'd3);
    move(1);
    chk("cursor_r1c3", 32'(reg_choose), 32'd7);
    move(1);
    chk("cursor_r2c3", 32'(reg_choose), 32'd11);
    move(3);
    chk("cursor_col_wrap", 32'(reg_choose), 32'd8);
    move(0); move(0);
    move(0);
    chk("cursor_row_wrap", 32'(reg_choose), 32'd12);
    move(1);

    fill_flag = 16'h0001;
    enter(2'd3, 1'b0, 1'b0, 1'b0);
    chk("locked_no_count", 32'(move_count), 32'd0);
    move(3);
    enter(2'd2, 1'b0, 1'b0, 1'b0);
    chk("first_write_count", 32'(move_count), 32'd1);

    enter(2'd1, 1'b0, 1'b0, 1'b1);
    chk("enter_beats_up", 32'(reg_choose), 32'd1);
    chk("budget_retry", 32'(try_again_flag), 32'd1);
    start_in_retry();
    chk("retry_keeps_diff", 32'(difficulty), 32'd2);

    move(3);
    enter(2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("won_hold");
    start_in_won();

    press_start_idle(2'b01);
    move(1);
    key_value = 2'd1;
    btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
    m_val = 2'd1; m_wr = 1;
    check_all("pre_reset_write");
    tick();
    m_wr = 0; m_chk = 1; m_moves = 1;
    check_all("pre_reset_check");
    restart = 1'b1;
    btn_start = 1'b1;
    tick();
    restart = 1'b0;
    model_clear();
    check_all("reset_in_check");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("held_start_ignored");
    end
    btn_start = 1'b0;
    tick();
    check_all("start_released");
    press_start_idle(2'b11);

    fill_flag = 16'($urandom) & 16'($urandom);
    for (int it = 0; it < 150; it++) begin
      if (m_won) begin
        start_in_won();
        fill_flag = 16'($urandom) & 16'($urandom);
        press_start_idle(2'($urandom_range(0, 3)));
      end else if (m_retry) begin
        start_in_retry();
      end else begin
        act = $urandom_range(0, 7);
        if (act < 4) move(act);
        else enter(2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
